player_motion: RTL and testbench
================================

Name: player_motion

Overview:
Per-frame motion controller for the blue player sprite, which is 47x41 px on a 640x480 playfield.
- Consumes the 4-bit collision vector from the collision detector and keyboard levels.
- Produces the sprite top-left position (x_blue, y_blue), which feeds back into the collision detector and the renderer.
- Implements walking, jump take-off, gravity-driven rise and fall, and landing.

Parameters:
X_INIT, 10'd40, x_blue after reset
Y_INIT, 9'd400, y_blue after reset
STEP_X, 2, horizontal pixels moved per frame tick
JUMP_V0, 8, initial upward speed in px/tick
GRAV_FRAMES, 2, frame ticks per 1 px/tick speed change
VMAX, 8, terminal fall speed in px/tick
X_MAX, 10'd593, rightmost legal x (640-47)
Y_MAX, 9'd439, lowest legal y (480-41)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame; all motion updates happen on it
key_left  in  1  level, move left
key_right  in  1  level, move right
key_jump  in  1  level, jump key
is_Collision  in  4  bit0 down, bit1 up, bit2 right, bit3 left (registered upstream)
x_blue  out  10  sprite x
y_blue  out  9  sprite y
mstate  out  2  0 GROUND, 1 RISE, 2 FALL
airborne  out  1  mstate != GROUND

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-jump):
  - x_blue=X_INIT, y_blue=Y_INIT, mstate=GROUND.
  - vy=0, grav_cnt=0, jump_req=0, key_jump_d=0.
- Jump request latch:
  - key_jump_d is key_jump delayed by one cycle.
  - A rising edge (key_jump & ~key_jump_d) sets jump_req.
  - jump_req clears on every frame_tick.
  - An edge in the same cycle as frame_tick is consumed by that tick.
  - Holding the key never re-triggers a jump.
- Outputs, vy and grav_cnt change only in frame_tick cycles. is_Collision is sampled in that same cycle.
- Horizontal motion (every tick, in all states):
  - Left only and bit3=0: x -= STEP_X, floored at 0.
  - Right only and bit2=0: x += STEP_X, capped at X_MAX.
  - Both keys or neither key: x holds.
- GROUND state:
  - jump_req=1 and bit1=0: y -= JUMP_V0 (floor 0), vy=JUMP_V0, grav_cnt=1, go to RISE.
  - Otherwise, if bit0=0 and y<Y_MAX (walked off an edge): vy=1, grav_cnt=0, go to FALL.
  - Otherwise stay; y holds.
- RISE state:
  - If bit1=1 or y==0 (head bump): y holds, vy=1, grav_cnt=0, go to FALL.
  - Otherwise y -= vy (floor 0) and grav_cnt increments.
  - When grav_cnt reaches GRAV_FRAMES, grav_cnt=0 and vy decrements.
  - If vy becomes 0: vy=1, go to FALL.
- FALL state:
  - If bit0=1 or y>=Y_MAX: go to GROUND, vy=0, grav_cnt=0, y holds.
  - Otherwise y += vy (capped at Y_MAX) and grav_cnt increments.
  - When grav_cnt reaches GRAV_FRAMES, grav_cnt=0 and vy increments, saturating at VMAX.
- Width rules:
  - All x arithmetic is 11-bit, all y arithmetic is 10-bit, before clamping.
  - No wrap-around is permitted.
- The collision vector lags position by one clk. The frame_tick spacing is at least 2 clk, so no hazard arises.

Decomposition:
- Shared package player_pkg holds:
  - mstate encoding (GROUND/RISE/FALL)
  - collision bit indices COLL_DOWN=0, COLL_UP=1, COLL_RIGHT=2, COLL_LEFT=3
  - sprite size 47x41 and screen size 640x480
- One sub-module, key_edge_latch: rising-edge detect plus sticky request, cleared by frame_tick.

Test Plan:
- Reset during RISE with y=350 -> outputs immediately return to x=40, y=400, mstate=GROUND, airborne=0.
- Floor support (bit0=1), right held for 10 ticks from x=40 -> x=60. With bit2=1 -> x holds at 60. At x=592, 1 tick -> x=593 (capped).
- From GROUND y=400, bit0=1, jump edge then ticks with no collisions -> y=392 after tick 1. Apex y=328 after 16 ticks, then mstate=FALL with vy=1.
- Jump held continuously across 40 ticks -> exactly one take-off. A second take-off requires release and a new press.
- FALL from y=328 with no support -> y advances 1,1,2,2,3,... up to 8 px/tick. When bit0=1 -> GROUND on that tick, y holds.
- GROUND with bit0 forced to 0 at y=400 -> FALL on the next tick, y=401. RISE with bit1=1 -> y holds, FALL, vy=1.

Source files
------------

// File: rtl/player_pkg.sv
// Shared encodings for the blue player sprite: motion states, collision bit map, geometry.
package player_pkg;

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_RISE   = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;

    localparam int COLL_DOWN  = 0;
    localparam int COLL_UP    = 1;
    localparam int COLL_RIGHT = 2;
    localparam int COLL_LEFT  = 3;

    localparam int SPRITE_W = 47;
    localparam int SPRITE_H = 41;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/key_edge_latch.sv
// Rising-edge detector with a sticky request, cleared by i_clr; o_req is combinational
// so an edge arriving in the i_clr cycle is still seen (and consumed) by that cycle.
module key_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    input  logic i_clr,
    output logic o_req
);

    logic r_key_d;
    logic r_req;
    logic w_edge;

    assign w_edge = i_key & ~r_key_d;
    assign o_req  = r_req | w_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_d <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_key_d <= i_key;
            r_req   <= i_clr ? 1'b0 : (r_req | w_edge);
        end
    end

endmodule

// File: rtl/player_motion.sv
// Per-frame walk/jump/gravity controller for the blue sprite; state advances only on frame_tick.
// Position is registered, so collision feedback for the new position arrives one clk later.
module player_motion
    import player_pkg::*;
#(
    parameter logic [9:0] X_INIT      = 10'd40,
    parameter logic [8:0] Y_INIT      = 9'd400,
    parameter int         STEP_X      = 2,
    parameter int         JUMP_V0     = 8,
    parameter int         GRAV_FRAMES = 2,
    parameter int         VMAX        = 8,
    parameter logic [9:0] X_MAX       = 10'(SCREEN_W - SPRITE_W),
    parameter logic [8:0] Y_MAX       = 9'(SCREEN_H - SPRITE_H)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic [3:0] is_Collision,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic [1:0] mstate,
    output logic       airborne
);

    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [1:0]  r_st;
    logic [3:0]  r_vy;
    logic [3:0]  r_grav;

    logic        w_jump_req;
    logic [10:0] w_x_ext;
    logic [10:0] w_x_sub;
    logic [10:0] w_x_add;
    logic [9:0]  w_y_ext;
    logic [9:0]  w_vy_ext;
    logic [9:0]  w_y_up;
    logic [9:0]  w_y_dn;
    logic [9:0]  w_y_jmp;
    logic [3:0]  w_g_inc;
    logic        w_g_hit;
    logic        w_c_down;
    logic        w_c_up;

    logic [9:0]  w_x_nxt;
    logic [8:0]  w_y_nxt;
    logic [1:0]  w_st_nxt;
    logic [3:0]  w_vy_nxt;
    logic [3:0]  w_g_nxt;

    key_edge_latch u_jump_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .i_key (key_jump),
        .i_clr (frame_tick),
        .o_req (w_jump_req)
    );

    // Widened operands: the top bit of a subtraction doubles as the underflow flag.
    assign w_x_ext  = {1'b0, r_x};
    assign w_x_sub  = w_x_ext - 11'(STEP_X);
    assign w_x_add  = w_x_ext + 11'(STEP_X);
    assign w_y_ext  = {1'b0, r_y};
    assign w_vy_ext = {6'b0, r_vy};
    assign w_y_up   = w_y_ext - w_vy_ext;
    assign w_y_dn   = w_y_ext + w_vy_ext;
    assign w_y_jmp  = w_y_ext - 10'(JUMP_V0);
    assign w_g_inc  = r_grav + 4'd1;
    assign w_g_hit  = (w_g_inc == 4'(GRAV_FRAMES));
    assign w_c_down = is_Collision[COLL_DOWN];
    assign w_c_up   = is_Collision[COLL_UP];

    always_comb begin
        w_x_nxt = r_x;
        if (key_left && !key_right && !is_Collision[COLL_LEFT]) begin
            w_x_nxt = w_x_sub[10] ? 10'd0 : w_x_sub[9:0];
        end else if (key_right && !key_left && !is_Collision[COLL_RIGHT]) begin
            w_x_nxt = (w_x_add > {1'b0, X_MAX}) ? X_MAX : w_x_add[9:0];
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        w_y_nxt  = r_y;
        w_vy_nxt = r_vy;
        w_g_nxt  = r_grav;
        case (r_st)
            ST_GROUND: begin
                if (w_jump_req && !w_c_up) begin
                    w_y_nxt  = w_y_jmp[9] ? 9'd0 : w_y_jmp[8:0];
                    w_vy_nxt = 4'(JUMP_V0);
                    w_g_nxt  = 4'd1;
                    w_st_nxt = ST_RISE;
                end else if (!w_c_down && (r_y < Y_MAX)) begin
                    w_vy_nxt = 4'd1;
                    w_g_nxt  = 4'd0;
                    w_st_nxt = ST_FALL;
                end
            end
            ST_RISE: begin
                if (w_c_up || (r_y == 9'd0)) begin
                    w_vy_nxt = 4'd1;
                    w_g_nxt  = 4'd0;
                    w_st_nxt = ST_FALL;
                end else begin
                    w_y_nxt = w_y_up[9] ? 9'd0 : w_y_up[8:0];
                    w_g_nxt = w_g_inc;
                    if (w_g_hit) begin
                        w_g_nxt = 4'd0;
                        // Apex: speed would hit zero, so start the descent at 1 px/tick.
                        if (r_vy <= 4'd1) begin
                            w_vy_nxt = 4'd1;
                            w_st_nxt = ST_FALL;
                        end else begin
                            w_vy_nxt = r_vy - 4'd1;
                        end
                    end
                end
            end
            ST_FALL: begin
                if (w_c_down || (r_y >= Y_MAX)) begin
                    w_vy_nxt = 4'd0;
                    w_g_nxt  = 4'd0;
                    w_st_nxt = ST_GROUND;
                end else begin
                    w_y_nxt = (w_y_dn > {1'b0, Y_MAX}) ? Y_MAX : w_y_dn[8:0];
                    w_g_nxt = w_g_inc;
                    if (w_g_hit) begin
                        w_g_nxt  = 4'd0;
                        w_vy_nxt = (r_vy >= 4'(VMAX)) ? 4'(VMAX) : r_vy + 4'd1;
                    end
                end
            end
            default: begin
                w_vy_nxt = 4'd0;
                w_g_nxt  = 4'd0;
                w_st_nxt = ST_GROUND;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= X_INIT;
            r_y    <= Y_INIT;
            r_st   <= ST_GROUND;
            r_vy   <= 4'd0;
            r_grav <= 4'd0;
        end else if (frame_tick) begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_st   <= w_st_nxt;
            r_vy   <= w_vy_nxt;
            r_grav <= w_g_nxt;
        end
    end

    assign x_blue   = r_x;
    assign y_blue   = r_y;
    assign mstate   = r_st;
    assign airborne = (r_st != ST_GROUND);

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: walking, jump arc, fall, landing, head bump, async reset.
module tb_player_motion;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       key_left;
    logic       key_right;
    logic       key_jump;
    logic [3:0] is_Collision;
    logic [9:0] x_blue;
    logic [8:0] y_blue;
    logic [1:0] mstate;
    logic       airborne;

    int n_pass;
    int n_total;

    player_motion dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .key_left     (key_left),
        .key_right    (key_right),
        .key_jump     (key_jump),
        .is_Collision (is_Collision),
        .x_blue       (x_blue),
        .y_blue       (y_blue),
        .mstate       (mstate),
        .airborne     (airborne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame tick: pulse for one clk, then one idle clk; outputs sampled on the negedge.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic press_jump();
        @(negedge clk);
        key_jump = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_tick = 1'b0; key_left = 1'b0; key_right = 1'b0;
        key_jump = 1'b0; is_Collision = 4'b0001;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (x_blue !== 10'd40) $display("FAIL reset_x got %0d want 40", x_blue); else n_pass++;
        n_total++; if (y_blue !== 9'd400) $display("FAIL reset_y got %0d want 400", y_blue); else n_pass++;
        n_total++; if (mstate !== 2'd0) $display("FAIL reset_state got %0d want 0", mstate); else n_pass++;
        n_total++; if (airborne !== 1'b0) $display("FAIL reset_airborne got %0b want 0", airborne); else n_pass++;
    endtask

    task automatic test_walk();
        is_Collision = 4'b0001;
        key_right = 1'b1;
        repeat (10) tick();
        n_total++; if (x_blue !== 10'd60) $display("FAIL walk_right10 got %0d want 60", x_blue); else n_pass++;
        is_Collision = 4'b0101;
        repeat (3) tick();
        n_total++; if (x_blue !== 10'd60) $display("FAIL walk_right_blocked got %0d want 60", x_blue); else n_pass++;
        is_Collision = 4'b0001;
        key_right = 1'b0; key_left = 1'b1;
        tick();
        n_total++; if (x_blue !== 10'd58) $display("FAIL walk_left1 got %0d want 58", x_blue); else n_pass++;
        key_right = 1'b1;
        repeat (2) tick();
        n_total++; if (x_blue !== 10'd58) $display("FAIL walk_both_keys got %0d want 58", x_blue); else n_pass++;
        key_left = 1'b0;
        repeat (267) tick();
        n_total++; if (x_blue !== 10'd592) $display("FAIL walk_to_592 got %0d want 592", x_blue); else n_pass++;
        tick();
        n_total++; if (x_blue !== 10'd593) $display("FAIL walk_cap_593 got %0d want 593", x_blue); else n_pass++;
        tick();
        n_total++; if (x_blue !== 10'd593) $display("FAIL walk_cap_hold got %0d want 593", x_blue); else n_pass++;
        key_right = 1'b0; key_left = 1'b1;
        repeat (296) tick();
        n_total++; if (x_blue !== 10'd1) $display("FAIL walk_to_1 got %0d want 1", x_blue); else n_pass++;
        tick();
        n_total++; if (x_blue !== 10'd0) $display("FAIL walk_floor_0 got %0d want 0", x_blue); else n_pass++;
        tick();
        n_total++; if (x_blue !== 10'd0) $display("FAIL walk_floor_hold got %0d want 0", x_blue); else n_pass++;
        key_left = 1'b0; key_right = 1'b1;
        repeat (20) tick();
        key_right = 1'b0;
        n_total++; if (x_blue !== 10'd40) $display("FAIL walk_back_40 got %0d want 40", x_blue); else n_pass++;
        n_total++; if (y_blue !== 9'd400) $display("FAIL walk_y_steady got %0d want 400", y_blue); else n_pass++;
    endtask

    task automatic test_jump_arc_and_fall();
        int exp_rise [16] = '{392, 384, 377, 370, 364, 358, 353, 348,
                              344, 340, 337, 334, 332, 330, 329, 328};
        int exp_fall [16] = '{329, 330, 332, 334, 337, 340, 344, 348,
                              353, 358, 364, 370, 377, 384, 392, 400};
        is_Collision = 4'b0001;
        press_jump();
        is_Collision = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_total++;
            if (y_blue !== 9'(exp_rise[i])) $display("FAIL rise_y[%0d] got %0d want %0d", i, y_blue, exp_rise[i]);
            else n_pass++;
            if (i == 0) begin
                n_total++; if (mstate !== 2'd1) $display("FAIL takeoff_state got %0d want 1", mstate); else n_pass++;
                n_total++; if (airborne !== 1'b1) $display("FAIL takeoff_airborne got %0b want 1", airborne); else n_pass++;
            end
        end
        key_jump = 1'b0;
        n_total++; if (mstate !== 2'd2) $display("FAIL apex_state got %0d want 2", mstate); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_total++;
            if (y_blue !== 9'(exp_fall[i])) $display("FAIL fall_y[%0d] got %0d want %0d", i, y_blue, exp_fall[i]);
            else n_pass++;
        end
        is_Collision = 4'b0001;
        tick();
        n_total++; if (mstate !== 2'd0) $display("FAIL land_state got %0d want 0", mstate); else n_pass++;
        n_total++; if (y_blue !== 9'd400) $display("FAIL land_y got %0d want 400", y_blue); else n_pass++;
    endtask

    task automatic test_jump_hold();
        int    takeoffs;
        logic [1:0] prev;
        takeoffs = 0;
        is_Collision = 4'b0001;
        press_jump();
        for (int i = 0; i < 40; i++) begin
            prev = mstate;
            tick();
            if (prev == 2'd0 && mstate == 2'd1) takeoffs++;
        end
        n_total++; if (takeoffs !== 1) $display("FAIL hold_takeoffs got %0d want 1", takeoffs); else n_pass++;
        n_total++; if (y_blue !== 9'd328) $display("FAIL hold_y got %0d want 328", y_blue); else n_pass++;
        n_total++; if (mstate !== 2'd0) $display("FAIL hold_state got %0d want 0", mstate); else n_pass++;
        key_jump = 1'b0;
        repeat (2) @(negedge clk);
        press_jump();
        key_right = 1'b1;
        tick();
        key_right = 1'b0;
        n_total++; if (y_blue !== 9'd320) $display("FAIL retrigger_y got %0d want 320", y_blue); else n_pass++;
        n_total++; if (mstate !== 2'd1) $display("FAIL retrigger_state got %0d want 1", mstate); else n_pass++;
        n_total++; if (x_blue !== 10'd42) $display("FAIL air_walk_x got %0d want 42", x_blue); else n_pass++;
    endtask

    task automatic test_reset_mid_jump();
        key_jump = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (x_blue !== 10'd40) $display("FAIL areset_x got %0d want 40", x_blue); else n_pass++;
        n_total++; if (y_blue !== 9'd400) $display("FAIL areset_y got %0d want 400", y_blue); else n_pass++;
        n_total++; if (mstate !== 2'd0) $display("FAIL areset_state got %0d want 0", mstate); else n_pass++;
        n_total++; if (airborne !== 1'b0) $display("FAIL areset_airborne got %0b want 0", airborne); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_walk_off_fall();
        int exp_y [13] = '{400, 401, 402, 404, 406, 409, 412, 416, 420, 425, 430, 436, 439};
        is_Collision = 4'b0000;
        for (int i = 0; i < 13; i++) begin
            tick();
            n_total++;
            if (y_blue !== 9'(exp_y[i])) $display("FAIL walkoff_y[%0d] got %0d want %0d", i, y_blue, exp_y[i]);
            else n_pass++;
            if (i == 0) begin
                n_total++; if (mstate !== 2'd2) $display("FAIL walkoff_state got %0d want 2", mstate); else n_pass++;
            end
        end
        tick();
        n_total++; if (mstate !== 2'd0) $display("FAIL floor_land_state got %0d want 0", mstate); else n_pass++;
        tick();
        n_total++; if (y_blue !== 9'd439) $display("FAIL floor_rest_y got %0d want 439", y_blue); else n_pass++;
        n_total++; if (mstate !== 2'd0) $display("FAIL floor_rest_state got %0d want 0", mstate); else n_pass++;
    endtask

    task automatic test_head_bump();
        is_Collision = 4'b0011;
        press_jump();
        tick();
        key_jump = 1'b0;
        n_total++; if (mstate !== 2'd0) $display("FAIL blocked_jump_state got %0d want 0", mstate); else n_pass++;
        n_total++; if (y_blue !== 9'd439) $display("FAIL blocked_jump_y got %0d want 439", y_blue); else n_pass++;
        is_Collision = 4'b0001;
        @(negedge clk);
        press_jump();
        tick();
        key_jump = 1'b0;
        n_total++; if (y_blue !== 9'd431) $display("FAIL bump_takeoff_y got %0d want 431", y_blue); else n_pass++;
        is_Collision = 4'b0010;
        tick();
        n_total++; if (y_blue !== 9'd431) $display("FAIL bump_hold_y got %0d want 431", y_blue); else n_pass++;
        n_total++; if (mstate !== 2'd2) $display("FAIL bump_state got %0d want 2", mstate); else n_pass++;
        is_Collision = 4'b0000;
        tick();
        n_total++; if (y_blue !== 9'd432) $display("FAIL bump_fall1 got %0d want 432", y_blue); else n_pass++;
        tick();
        n_total++; if (y_blue !== 9'd433) $display("FAIL bump_fall2 got %0d want 433", y_blue); else n_pass++;
        tick();
        n_total++; if (y_blue !== 9'd435) $display("FAIL bump_fall3 got %0d want 435", y_blue); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_walk();
        test_jump_arc_and_fall();
        test_jump_hold();
        test_reset_mid_jump();
        test_walk_off_fall();
        test_head_bump();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
